// File: rtl/microcode_pkg.sv
// Shared definitions for the control-unit microprogram store:
// field widths, condition codes, op-strobe indices and the ROM contents.
package microcode_pkg;

    localparam int ADDR_W   = 16;
    localparam int OPS_W    = 51;
    localparam int WORD_W   = 70;
    localparam int ROM_DEPTH = 8;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_CARRY  = 2'b10;
    localparam logic [1:0] COND_NEVER  = 2'b11;

    localparam int OP_FETCH    = 0;
    localparam int OP_IR_LOAD  = 1;
    localparam int OP_PC_INC   = 2;
    localparam int OP_ALU_ADD  = 3;
    localparam int OP_MEM_WR   = 4;
    localparam int OP_ACC_LOAD = 5;

    // Packed MSB-first so the struct bit layout is the 70-bit word format.
    typedef struct packed {
        logic              bt;
        logic [1:0]        cond;
        logic [OPS_W-1:0]  ops;
        logic [ADDR_W-1:0] jump;
    } uinst_t;

    localparam uinst_t NOP_WORD = '0;

    // Only the low 3 address bits select a word; range checking is the caller's job.
    function automatic uinst_t rom_word(input logic [2:0] a);
        uinst_t w;
        w = NOP_WORD;
        case (a)
            3'd0: w.ops[OP_FETCH] = 1'b1;
            3'd1: begin
                w.ops[OP_IR_LOAD] = 1'b1;
                w.ops[OP_PC_INC]  = 1'b1;
            end
            3'd2: begin
                w.bt   = 1'b1;
                w.cond = COND_ZERO;
                w.jump = 16'd5;
            end
            3'd3: w.ops[OP_ALU_ADD] = 1'b1;
            3'd4: begin
                w.bt   = 1'b1;
                w.cond = COND_ALWAYS;
                w.jump = 16'd0;
            end
            3'd5: w.ops[OP_MEM_WR] = 1'b1;
            3'd6: begin
                w.bt   = 1'b1;
                w.cond = COND_CARRY;
                w.ops[OP_ACC_LOAD] = 1'b1;
                w.jump = 16'd1;
            end
            default: begin
                w.bt   = 1'b1;
                w.cond = COND_NEVER;
                w.jump = 16'd7;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Microprogram ROM: combinational lookup of the micro-PC address followed by a
// single output register, so every field changes together one cycle later.
module microcode_rom
    import microcode_pkg::*;
#(
    parameter int ADDR_W = microcode_pkg::ADDR_W,
    parameter int DEPTH  = ROM_DEPTH,
    parameter int OPS_W  = microcode_pkg::OPS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg_out,
    output logic [1:0]        condition,
    output logic              BT,
    output logic [OPS_W-1:0]  OPs,
    output logic [ADDR_W-1:0] jump_addr
);

    uinst_t word_d, word_q;

    // Anything past the populated words reads as NOP so the sequencer never sees X.
    always_comb begin
        word_d = NOP_WORD;
        if (reg_out < ADDR_W'(DEPTH))
            word_d = rom_word(reg_out[2:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_q <= NOP_WORD;
        else
            word_q <= word_d;
    end

    assign BT        = word_q.bt;
    assign condition = word_q.cond;
    assign OPs       = word_q.ops;
    assign jump_addr = word_q.jump;

endmodule

// File: tb/tb_microcode_rom.sv
// Self-checking bench for microcode_rom against a table-driven reference model.
module tb_microcode_rom;

    logic        clk;
    logic        rst_n;
    logic [15:0] reg_out;
    logic [1:0]  condition;
    logic        BT;
    logic [50:0] OPs;
    logic [15:0] jump_addr;

    int errors = 0;
    int checks = 0;

    // Reference table straight from the ROM contents listing.
    int bt_t   [8] = '{0, 0, 1, 0, 1, 0, 1, 1};
    int cond_t [8] = '{0, 0, 1, 0, 0, 0, 2, 3};
    int ops_t  [8] = '{1, 6, 0, 8, 0, 16, 32, 0};
    int jmp_t  [8] = '{0, 0, 5, 0, 0, 0, 1, 7};

    microcode_rom dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_out  (reg_out),
        .condition(condition),
        .BT       (BT),
        .OPs      (OPs),
        .jump_addr(jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] ref_word(input logic [15:0] a);
        logic [69:0] w;
        int i;
        w = '0;
        if (a < 16'd8) begin
            i = int'(a);
            w[69]    = bt_t[i][0];
            w[68:67] = cond_t[i][1:0];
            w[66:16] = 51'(ops_t[i]);
            w[15:0]  = jmp_t[i][15:0];
        end
        return w;
    endfunction

    function automatic logic [69:0] obs();
        return {BT, condition, OPs, jump_addr};
    endfunction

    task automatic check(input string name, input logic [69:0] exp);
        // inline compare wrapper kept minimal; each test supplies its own name
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs(), exp);
        end
    endtask

    // Apply an address mid-cycle, then sample just after the next rising edge.
    task automatic step(input logic [15:0] a);
        @(negedge clk);
        reg_out = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        reg_out = 16'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== 70'd0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 0", obs());
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== ref_word(16'd3)) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs(), ref_word(16'd3));
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 8; a++) begin
            step(16'(a));
            checks++;
            if (obs() !== ref_word(16'(a))) begin
                errors++;
                $display("FAIL sweep_addr%0d: got %h expected %h", a, obs(), ref_word(16'(a)));
            end
        end
    endtask

    task automatic test_latency();
        step(16'd1);
        @(negedge clk);
        reg_out = 16'd4;
        #2;
        checks++;
        if (obs() !== ref_word(16'd1)) begin
            errors++;
            $display("FAIL latency_hold: got %h expected %h", obs(), ref_word(16'd1));
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== ref_word(16'd4)) begin
            errors++;
            $display("FAIL latency_update: got %h expected %h", obs(), ref_word(16'd4));
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] addrs [4] = '{16'd8, 16'hFFFF, 16'd16, 16'h8003};
        foreach (addrs[k]) begin
            step(16'd6);
            step(addrs[k]);
            checks++;
            if (obs() !== 70'd0) begin
                errors++;
                $display("FAIL oor_%h: got %h expected 0", addrs[k], obs());
            end
        end
    endtask

    task automatic test_async_reset();
        step(16'd6);
        checks++;
        if (obs() !== ref_word(16'd6)) begin
            errors++;
            $display("FAIL async_pre: got %h expected %h", obs(), ref_word(16'd6));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 70'd0) begin
            errors++;
            $display("FAIL async_clear: got %h expected 0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== ref_word(16'd6)) begin
            errors++;
            $display("FAIL async_recover: got %h expected %h", obs(), ref_word(16'd6));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            logic [15:0] a;
            a = (n % 2 == 0) ? 16'd2 : 16'd5;
            step(a);
            checks++;
            if (obs() !== ref_word(a)) begin
                errors++;
                $display("FAIL b2b_%0d: got %h expected %h", n, obs(), ref_word(a));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 3) == 0)
                a = 16'($urandom);
            else
                a = 16'($urandom_range(0, 11));
            step(a);
            checks++;
            if (obs() !== ref_word(a)) begin
                errors++;
                $display("FAIL random_%0d addr %h: got %h expected %h", n, a, obs(), ref_word(a));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        reg_out = '0;
        test_reset();
        test_sweep();
        test_latency();
        test_out_of_range();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microcode_rom.md
Name: microcode_rom

Overview:
- Microprogram store for the control unit sequencer.
- It is indexed by the micro-program counter value `reg_out`.
- It returns one registered micro-instruction with these fields:
  - branch flag `BT`
  - 2-bit branch condition select `condition`, which feeds the control unit's condition mux
  - 51 control-op strobes `OPs`
  - 16-bit branch target `jump_addr`
- It sits between the micro-PC register and the datapath control fan-out.

Parameters:
- ADDR_W, 16, width of micro-address `reg_out`.
- DEPTH, 8, number of populated ROM words. Addresses 0..DEPTH-1 are valid.
- OPS_W, 51, width of the control-op strobe field.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reg_out  input  16  micro-address from the micro-PC register.
- condition  output  2  branch condition select: 00 always, 01 zero flag, 10 carry flag, 11 never.
- BT  output  1  branch type: 1 means a branch micro-instruction (use `jump_addr` when the condition holds), 0 means sequential.
- OPs  output  51  one-hot-or-multi-hot control strobes for the datapath.
- jump_addr  output  16  micro-address loaded into the micro-PC on a taken branch.

Behaviour:
- Word format, 70 bits, MSB to LSB: {BT[69], condition[68:67], OPs[66:16], jump_addr[15:0]}.
- Reset:
  - While rst_n=0, asynchronously force BT=0, condition=00, OPs=0 and jump_addr=0 (the NOP word).
  - On the first rising clk edge after rst_n returns high, the output reflects the `reg_out` sampled at that edge.
- Latency:
  - Exactly one cycle. `reg_out` is sampled on a rising clk edge, and all four outputs present ROM[reg_out] immediately after that edge.
  - All four fields update together; no partial updates.
- Outputs hold between edges and are glitch-free, because they come straight from registers.
- Out-of-range address (reg_out >= DEPTH): output the NOP word. Never X.
- The ROM is constant combinational logic with no write port. The contents are fixed at elaboration:

| Addr | BT | condition | OPs bits set | jump_addr |
|---|---|---|---|---|
| 0 | 0 | 00 | bit0 (FETCH) | 0 |
| 1 | 0 | 00 | bit1, bit2 (IR_LOAD, PC_INC) | 0 |
| 2 | 1 | 01 | none | 5 |
| 3 | 0 | 00 | bit3 (ALU_ADD) | 0 |
| 4 | 1 | 00 | none | 0 |
| 5 | 0 | 00 | bit4 (MEM_WR) | 0 |
| 6 | 1 | 10 | bit5 (ACC_LOAD) | 1 |
| 7 | 1 | 11 | none | 7 (halt self-loop) |

- Unlisted OPs bits are 0.
- The block does not evaluate conditions and does not sequence. The condition mux and micro-PC are external.
- Reset asserted mid-operation clears the outputs within the same cycle, independent of clk.
- Back-to-back address changes on consecutive cycles give consecutive words, with no bubbles.

Decomposition:
- Shared package `microcode_pkg` holds:
  - field widths ADDR_W=16 and OPS_W=51
  - word width 70
  - condition codes COND_ALWAYS=2'b00, COND_ZERO=2'b01, COND_CARRY=2'b10, COND_NEVER=2'b11
  - OPs bit indices OP_FETCH=0, OP_IR_LOAD=1, OP_PC_INC=2, OP_ALU_ADD=3, OP_MEM_WR=4, OP_ACC_LOAD=5
  - the NOP word constant
  - a packed micro-instruction struct
- No sub-module is needed. The ROM is a case/function inside microcode_rom, followed by a single output register stage.

Test Plan:
- Reset: hold rst_n=0 with reg_out=3, then toggle clk. All outputs stay 0. Deassert rst_n; the next edge gives OPs bit3=1, BT=0, condition=00, jump_addr=0.
- Sweep: drive reg_out=0..7, one per cycle. Each word matches the table one cycle later, including:
  - addr2: BT=1, cond=01, jump=5
  - addr6: BT=1, cond=10, OPs bit5, jump=1
  - addr7: BT=1, cond=11, jump=7
- Latency check: change reg_out from 1 to 4 between edges. The outputs must not change until the next rising edge, then show BT=1, cond=00, jump=0, OPs=0.
- Out-of-range: drive reg_out=8, then 16'hFFFF. The output is the NOP word (all zero), with no X.
- Async reset mid-run: with reg_out=6 stable and outputs showing word 6, assert rst_n=0 between clock edges. The outputs clear to zero immediately, before the next edge.
- Back-to-back: alternate reg_out between 2 and 5 every cycle. The outputs alternate between word 2 and word 5 with one-cycle lag and no stale fields.
